data_memory_stage: RTL and testbench

Memory-access stage of the five-stage pipeline, between the Execute-to-Memory register and the Memory-to-WriteBack register. It holds the data memory and performs word, halfword and byte stores, and signed or unsigned loads. Reads are synchronous, BRAM-style, so every load takes two cycles. The block raises `Stall` for the first cycle so upstream pipeline registers hold, and presents `ReadData` in the second cycle, when the Memory-to-WriteBack register samples it.

---
 rtl/data_memory_stage.sv | 150 +++++++++++++++
 tb/tb_data_memory_stage.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/data_memory_stage.sv
// data_memory_stage
//   Memory-access stage: holds the data memory and performs word, halfword
//   and byte stores plus signed/unsigned loads. Reads are synchronous, so a
//   load stalls the pipeline for one cycle and presents formatted data in the
//   following cycle (LOAD_WAIT).
// Ports
//   Clk, Reset      : pipeline clock, asynchronous active-high reset
//   Address         : byte address from the ALU
//   WriteData       : right-aligned store data
//   MemRead/MemWrite: load / store request
//   MemSize         : 00 word, 01 halfword, 10 byte, 11 word
//   MemUnsigned     : load zero-extends when 1, sign-extends when 0
//   ReadData        : formatted load result, valid in LOAD_WAIT, else 0
//   Stall           : hold upstream (first cycle of a load)
//   Misaligned      : current request is misaligned and suppressed
module data_memory_stage #(
  parameter int DEPTH_WORDS = 1024
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [31:0] Address,
  input  logic [31:0] WriteData,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [1:0]  MemSize,
  input  logic        MemUnsigned,
  output logic [31:0] ReadData,
  output logic        Stall,
  output logic        Misaligned
);
  localparam int AW = $clog2(DEPTH_WORDS);

  typedef enum logic {IDLE, LOAD_WAIT} state_t;

  state_t      state_q, state_d;
  logic [1:0]  off_q, off_d;
  logic [1:0]  size_q, size_d;
  logic        uns_q, uns_d;
  logic [31:0] rword_q;

  logic [31:0] mem [DEPTH_WORDS];

  logic [AW-1:0] idx;
  logic          is_idle, req, align_bad, rd_go, we;
  logic [3:0]    be;
  logic [31:0]   wdata;
  logic [7:0]    byte_sel;
  logic [15:0]   half_sel;

  // Upper address bits alias onto the array.
  logic addr_unused;
  assign addr_unused = ^Address[31:AW+2];

  assign idx     = Address[AW+1:2];
  assign is_idle = (state_q == IDLE);
  assign req     = MemRead | MemWrite;

  always_comb begin
    align_bad = 1'b0;
    case (MemSize)
      2'b01:   align_bad = Address[0];
      2'b10:   align_bad = 1'b0;
      default: align_bad = (Address[1:0] != 2'b00);
    endcase
  end

  // A load wins over a simultaneous store; LOAD_WAIT ignores all requests.
  assign rd_go = is_idle & MemRead & ~align_bad;
  assign we    = is_idle & MemWrite & ~MemRead & ~align_bad;

  // Byte enables and lane-replicated store data.
  always_comb begin
    be    = 4'b1111;
    wdata = WriteData;
    case (MemSize)
      2'b01: begin
        be    = Address[1] ? 4'b1100 : 4'b0011;
        wdata = {2{WriteData[15:0]}};
      end
      2'b10: begin
        be    = 4'b0001 << Address[1:0];
        wdata = {4{WriteData[7:0]}};
      end
      default: ;
    endcase
  end

  // Memory array and read register: not reset, BRAM-style.
  always_ff @(posedge Clk) begin
    if (we) begin
      for (int b = 0; b < 4; b++)
        if (be[b]) mem[idx][8*b +: 8] <= wdata[8*b +: 8];
    end
    if (rd_go) rword_q <= mem[idx];
  end

  // State register
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= IDLE;
      off_q   <= 2'b00;
      size_q  <= 2'b00;
      uns_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      off_q   <= off_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
    end
  end

  // Next state and captured request attributes
  always_comb begin
    state_d = state_q;
    off_d   = off_q;
    size_d  = size_q;
    uns_d   = uns_q;
    case (state_q)
      IDLE: if (rd_go) begin
        state_d = LOAD_WAIT;
        off_d   = Address[1:0];
        size_d  = MemSize;
        uns_d   = MemUnsigned;
      end
      LOAD_WAIT: state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    case (off_q)
      2'd0:    byte_sel = rword_q[7:0];
      2'd1:    byte_sel = rword_q[15:8];
      2'd2:    byte_sel = rword_q[23:16];
      default: byte_sel = rword_q[31:24];
    endcase
    half_sel   = off_q[1] ? rword_q[31:16] : rword_q[15:0];
    Stall      = rd_go;
    Misaligned = is_idle & req & align_bad;
    ReadData   = 32'h0;
    if (state_q == LOAD_WAIT) begin
      case (size_q)
        2'b01:   ReadData = uns_q ? {16'h0, half_sel} : {{16{half_sel[15]}}, half_sel};
        2'b10:   ReadData = uns_q ? {24'h0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
        default: ReadData = rword_q;
      endcase
    end
  end
endmodule

// File: tb/tb_data_memory_stage.sv
module tb_data_memory_stage;
  logic        Clk = 1'b0;
  logic        Reset;
  logic [31:0] Address, WriteData;
  logic        MemRead, MemWrite, MemUnsigned;
  logic [1:0]  MemSize;
  logic [31:0] ReadData;
  logic        Stall, Misaligned;

  int total = 0;
  int bad   = 0;

  data_memory_stage #(.DEPTH_WORDS(1024)) dut (
    .Clk(Clk), .Reset(Reset), .Address(Address), .WriteData(WriteData),
    .MemRead(MemRead), .MemWrite(MemWrite), .MemSize(MemSize),
    .MemUnsigned(MemUnsigned), .ReadData(ReadData), .Stall(Stall),
    .Misaligned(Misaligned)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle_in();
    MemRead = 0; MemWrite = 0; MemSize = 2'b00; MemUnsigned = 0;
    Address = 32'h0; WriteData = 32'h0;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz);
    @(negedge Clk);
    Address = a; WriteData = d; MemSize = sz; MemWrite = 1; MemRead = 0;
    #1;
    chk("st_stall", {31'h0, Stall}, 32'h0);
    chk("st_mis", {31'h0, Misaligned}, 32'h0);
    @(posedge Clk); #1;
    idle_in();
  endtask

  // Inputs (including MemWrite) stay applied through LOAD_WAIT to show they are ignored.
  task automatic load(input string tag, input logic [31:0] a, input logic [1:0] sz,
                      input logic u, input logic wr, input logic [31:0] exp);
    @(negedge Clk);
    Address = a; MemSize = sz; MemUnsigned = u; MemRead = 1; MemWrite = wr;
    WriteData = 32'h0;
    #1;
    chk({tag, "_stall1"}, {31'h0, Stall}, 32'h1);
    chk({tag, "_mis"}, {31'h0, Misaligned}, 32'h0);
    chk({tag, "_rd_n"}, ReadData, 32'h0);
    @(posedge Clk); #1;
    chk({tag, "_stall2"}, {31'h0, Stall}, 32'h0);
    chk({tag, "_data"}, ReadData, exp);
    @(negedge Clk);
    idle_in();
    @(posedge Clk); #1;
    chk({tag, "_rd_after"}, ReadData, 32'h0);
  endtask

  task automatic misal(input string tag, input logic [31:0] a, input logic [1:0] sz,
                       input logic rd, input logic wr);
    @(negedge Clk);
    Address = a; MemSize = sz; MemRead = rd; MemWrite = wr; WriteData = 32'hFFFF_FFFF;
    #1;
    chk({tag, "_mis"}, {31'h0, Misaligned}, 32'h1);
    chk({tag, "_stall"}, {31'h0, Stall}, 32'h0);
    chk({tag, "_rd"}, ReadData, 32'h0);
    @(posedge Clk); #1;
    chk({tag, "_rd_next"}, ReadData, 32'h0);
    chk({tag, "_stall_next"}, {31'h0, Stall}, 32'h0);
    idle_in();
  endtask

  initial begin
    idle_in();
    Reset = 1;
    #2;
    chk("rst_stall", {31'h0, Stall}, 32'h0);
    chk("rst_mis", {31'h0, Misaligned}, 32'h0);
    chk("rst_rd", ReadData, 32'h0);
    @(negedge Clk);
    Reset = 0;

    // Word store / load
    store(32'h10, 32'hDEADBEEF, 2'b00);
    load("lw10", 32'h10, 2'b00, 0, 0, 32'hDEADBEEF);

    // Byte and halfword lanes
    store(32'h20, 32'h80F17F01, 2'b00);
    load("lb20", 32'h20, 2'b10, 0, 0, 32'h00000001);
    load("lb21", 32'h21, 2'b10, 0, 0, 32'h0000007F);
    load("lb22", 32'h22, 2'b10, 0, 0, 32'hFFFFFFF1);
    load("lb23", 32'h23, 2'b10, 0, 0, 32'hFFFFFF80);
    load("lbu23", 32'h23, 2'b10, 1, 0, 32'h00000080);
    load("lh22", 32'h22, 2'b01, 0, 0, 32'hFFFF80F1);
    load("lhu22", 32'h22, 2'b01, 1, 0, 32'h000080F1);
    load("lhu20", 32'h20, 2'b01, 1, 0, 32'h00007F01);
    load("lw_sz3", 32'h20, 2'b11, 0, 0, 32'h80F17F01);

    // Partial stores
    store(32'h30, 32'h11223344, 2'b00);
    store(32'h31, 32'h000000AA, 2'b10);
    load("sb31", 32'h30, 2'b00, 0, 0, 32'h1122AA44);
    store(32'h32, 32'h0000BEEF, 2'b01);
    load("sh32", 32'h30, 2'b00, 0, 0, 32'hBEEFAA44);

    // Misaligned: suppressed, memory unchanged
    store(32'h40, 32'h55667788, 2'b00);
    misal("lw42", 32'h42, 2'b00, 1, 0);
    misal("sh41", 32'h41, 2'b01, 0, 1);
    misal("sw43", 32'h43, 2'b11, 0, 1);
    load("after_mis", 32'h40, 2'b00, 0, 0, 32'h55667788);

    // Read+write together acts as a load; the write is dropped
    load("rw10", 32'h10, 2'b00, 0, 1, 32'hDEADBEEF);
    load("rw10_chk", 32'h10, 2'b00, 0, 0, 32'hDEADBEEF);

    // Back-to-back loads with request held: stall 1,0,1,0
    @(negedge Clk);
    Address = 32'h20; MemSize = 2'b00; MemRead = 1;
    #1;
    chk("b2b_s0", {31'h0, Stall}, 32'h1);
    @(posedge Clk); #1;
    chk("b2b_s1", {31'h0, Stall}, 32'h0);
    chk("b2b_d1", ReadData, 32'h80F17F01);
    @(posedge Clk); #1;
    chk("b2b_s2", {31'h0, Stall}, 32'h1);
    chk("b2b_d2", ReadData, 32'h0);
    @(posedge Clk); #1;
    chk("b2b_s3", {31'h0, Stall}, 32'h0);
    chk("b2b_d3", ReadData, 32'h80F17F01);
    @(negedge Clk);
    idle_in();

    // Address wrap at 4*DEPTH_WORDS bytes
    store(32'h1004, 32'hCAFEF00D, 2'b00);
    load("wrap", 32'h0004, 2'b00, 0, 0, 32'hCAFEF00D);

    // Reset during LOAD_WAIT
    @(negedge Clk);
    Address = 32'h10; MemSize = 2'b00; MemRead = 1;
    @(posedge Clk); #1;
    chk("rml_data", ReadData, 32'hDEADBEEF);
    idle_in();
    Reset = 1;
    #1;
    chk("rml_rd", ReadData, 32'h0);
    chk("rml_stall", {31'h0, Stall}, 32'h0);
    @(negedge Clk);
    Reset = 0;
    load("post_rst", 32'h10, 2'b00, 0, 0, 32'hDEADBEEF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
